seven_seg_scanner: RTL and testbench

//   Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.

---
 rtl/seven_seg_scanner.sv | 117 +++++++++++
 tb/tb_seven_seg_scanner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// The 16-bit value is shown as hex digits; inputs are latched once per frame.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [3:0]  anode,
    output logic [7:0]  cathode,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    function automatic logic [6:0] hexseg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      shadow_value_q, shadow_value_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [3:0]       shadow_blank_q, shadow_blank_d;
    logic [3:0]       anode_q, anode_d;
    logic [7:0]       cathode_q, cathode_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       nib;

    always_comb begin
        cnt_d          = cnt_q;
        digit_d        = digit_q;
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        anode_d        = 4'hF;
        cathode_d      = 8'hFF;
        frame_done_d   = 1'b0;
        tick           = (cnt_q == CNT_MAX);
        wrap           = tick && (digit_q == 2'd3);
        nib            = shadow_value_q[{digit_q, 2'b00} +: 4];

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                digit_d = digit_q + 2'd1;
            end
            // Latch new inputs only at the frame boundary so a frame never mixes values.
            if (wrap) begin
                shadow_value_d = value;
                shadow_dp_d    = dp;
                shadow_blank_d = blank;
            end
            frame_done_d = wrap;
            // Outputs reflect the pre-update state and the pre-capture shadow.
            if (cnt_q >= GUARD_C && !shadow_blank_q[digit_q]) begin
                anode_d[digit_q] = 1'b0;
                cathode_d        = {~shadow_dp_q[digit_q], ~hexseg(nib)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            digit_q        <= 2'd0;
            shadow_value_q <= 16'h0000;
            shadow_dp_q    <= 4'h0;
            shadow_blank_q <= 4'hF;
            anode_q        <= 4'hF;
            cathode_q      <= 8'hFF;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            anode_q        <= anode_d;
            cathode_q      <= cathode_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a position-based display model predicts
// every output cycle; a second small instance is hammered with random input for invariants.
module tb_seven_seg_scanner;

    localparam int RD = 8;
    localparam int GD = 2;
    localparam int FRAME = 4 * RD;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ca;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, enable = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0, blank = '0;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame_done;

    logic        rst2 = 1'b1, en2 = 1'b0;
    logic [15:0] val2 = '0;
    logic [3:0]  dp2 = '0, bl2 = '0;
    logic [3:0]  an2;
    logic [7:0]  ca2;
    logic        fd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;
    bit started = 0;
    bit done = 0;
    exp_t exp_q[$];

    // Reference model: position within a frame plus the latched frame contents.
    int          pos = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_bl = 4'hF;
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_seg_scanner #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .dp(dp), .blank(blank),
        .anode(anode), .cathode(cathode), .frame_done(frame_done)
    );

    seven_seg_scanner #(.REFRESH_DIV(2), .GUARD(0)) dut2 (
        .clk(clk), .rst(rst2), .enable(en2), .value(val2), .dp(dp2), .blank(bl2),
        .anode(an2), .cathode(ca2), .frame_done(fd2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic r, input logic e, input logic [15:0] v,
                         input logic [3:0] d, input logic [3:0] b);
        exp_t x;
        int dg, c;
        @(negedge clk);
        rst = r; enable = e; value = v; dp = d; blank = b;
        x.an = 4'hF; x.ca = 8'hFF; x.fd = 1'b0;
        if (r) begin
            pos = 0; m_val = '0; m_dp = '0; m_bl = 4'hF;
        end else if (e) begin
            dg = pos / RD;
            c  = pos % RD;
            if (c >= GD && !m_bl[dg]) begin
                x.an = ~(4'b0001 << dg);
                x.ca = {~m_dp[dg], ~seg_tab[m_val[dg*4 +: 4]]};
            end
            if (pos == FRAME - 1) begin
                x.fd = 1'b1;
                m_val = v; m_dp = d; m_bl = b;
            end
            pos = (pos + 1) % FRAME;
        end
        exp_q.push_back(x);
        started = 1;
    endtask

    task automatic run(input int n, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, v, d, b);
    endtask

    // Monitor: one expected entry per clock edge once stimulus has begun.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (anode !== x.an || cathode !== x.ca || frame_done !== x.fd) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got an=%h ca=%h fd=%b want an=%h ca=%h fd=%b",
                             cyc, anode, cathode, frame_done, x.an, x.ca, x.fd);
                end
                if (x.fd && frame_done === 1'b1) frames_seen++;
            end
        end
    end

    task automatic chk_inv(input string nm, input logic [3:0] a, input logic [7:0] c,
                           input logic f, input logic pf);
        checks++;
        if ($countones(~a) > 1 || (a === 4'hF && c !== 8'hFF) || (f === 1'b1 && pf === 1'b1)
            || $isunknown({a, c, f})) begin
            errors++;
            $display("FAIL invariant_%s cyc=%0d got an=%h ca=%h fd=%b prev_fd=%b want one-hot-low an, dark ca when off, no back-to-back fd",
                     nm, cyc, a, c, f, pf);
        end
    endtask

    logic pf1 = 1'b0, pf2 = 1'b0;
    int   c2 = 0;
    always @(negedge clk) begin
        if (started && c2 > 3) begin
            chk_inv("main", anode, cathode, frame_done, pf1);
            chk_inv("fast", an2, ca2, fd2, pf2);
        end
        pf1 = frame_done;
        pf2 = fd2;
    end

    // Random hammer for the REFRESH_DIV=2, GUARD=0 instance.
    always @(negedge clk) begin
        c2   <= c2 + 1;
        rst2 = (c2 < 3) || ($urandom_range(0, 49) == 0);
        en2  = ($urandom_range(0, 9) != 0);
        val2 = 16'($urandom);
        dp2  = 4'($urandom);
        bl2  = 4'($urandom);
    end

    initial begin
        // Reset, run partway into a slot, then reset mid-slot.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        run(5, 16'h1234, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        // Capture: first frame dark, second shows 1234.
        run(2 * FRAME, 16'h1234, 4'h0, 4'h0);
        // Tearing: new value mid-frame must wait for the next wrap.
        run(10, 16'h1234, 4'h0, 4'h0);
        run(2 * FRAME, 16'hFFFF, 4'h0, 4'h0);
        // Decimal point on digit 2, digit 3 blanked.
        run(3 * FRAME, 16'hA5C3, 4'b0100, 4'b1000);
        // Park at digit 1, cnt 5 then freeze for 10 cycles.
        for (int i = 0; i < FRAME && pos != RD + 5; i++) drive(1'b0, 1'b1, 16'hA5C3, 4'b0100, 4'b1000);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 16'hA5C3, 4'b0100, 4'b1000);
        run(2 * FRAME, 16'hA5C3, 4'b0100, 4'b1000);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                  16'($urandom), 4'($urandom), 4'($urandom));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (frames_seen < 4) begin
            errors++;
            $display("FAIL frame_pulses got %0d want >=4", frames_seen);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
